// File: rtl/sched_pkg.sv
// Shared opcodes, NOP encoding, scheduler state and RV32 decode helpers
// for the dual-issue scheduler.
package sched_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {NORMAL, SPLIT_B} sched_state_t;

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_LUI) || (op == OP_AUIPC) ||
           (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational check deciding whether an instruction pair must split:
// intra-pair RAW, two memory ops, or control flow in the older slot.
module pair_hazard_check
  import sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] instr_a,
  input  logic [DATA_WIDTH-1:0] instr_b,
  input  logic                  valid_b,
  output logic                  split_o
);

  logic [6:0]                op_a;
  logic [6:0]                op_b;
  logic [REG_ADDR_WIDTH-1:0] rd_a;
  logic [REG_ADDR_WIDTH-1:0] rs1_b;
  logic [REG_ADDR_WIDTH-1:0] rs2_b;
  logic                      raw;
  logic                      mem;
  logic                      ctrl;

  assign op_a  = instr_a[6:0];
  assign op_b  = instr_b[6:0];
  assign rd_a  = instr_a[7 +: REG_ADDR_WIDTH];
  assign rs1_b = instr_b[15 +: REG_ADDR_WIDTH];
  assign rs2_b = instr_b[20 +: REG_ADDR_WIDTH];

  assign raw = writes_rd(op_a) && (rd_a != '0) &&
               ((reads_rs1(op_b) && (rs1_b == rd_a)) ||
                (reads_rs2(op_b) && (rs2_b == rd_a)));
  assign mem  = is_mem(op_a) && is_mem(op_b);
  assign ctrl = is_ctrl(op_a);

  assign split_o = valid_b && (raw || mem || ctrl);

  logic unused_bits;
  assign unused_bits = ^{instr_a[DATA_WIDTH-1:12],
                         instr_b[DATA_WIDTH-1:25],
                         instr_b[14:7]};

endmodule

// File: rtl/dual_issue_scheduler.sv
// Pairs fetched instructions onto two decode lanes, splitting hazardous
// pairs over two cycles. SCHED_PERF_CNT_EN adds dual/split counters.
module dual_issue_scheduler
  import sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  PairValidA_i,
  input  logic                  PairValidB_i,
  input  logic [DATA_WIDTH-1:0] InstrA_i,
  input  logic [DATA_WIDTH-1:0] InstrB_i,
  input  logic                  Stall_i,
  input  logic                  Flush_i,
  output logic                  PairReady_o,
  output logic                  IssueValidA_o,
  output logic                  IssueValidB_o,
  output logic [DATA_WIDTH-1:0] IssueInstrA_o,
  output logic [DATA_WIDTH-1:0] IssueInstrB_o
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]           DualCount_o,
  output logic [31:0]           SplitCount_o
`endif
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

  sched_state_t          state, state_n;
  logic                  va, va_n;
  logic                  vb, vb_n;
  logic [DATA_WIDTH-1:0] ia, ia_n;
  logic [DATA_WIDTH-1:0] ib, ib_n;
  logic [DATA_WIDTH-1:0] held, held_n;
  logic                  split;
  logic                  accept;
  logic                  dual;

  pair_hazard_check #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hazard (
    .instr_a(InstrA_i),
    .instr_b(InstrB_i),
    .valid_b(PairValidB_i),
    .split_o(split)
  );

  assign PairReady_o = (state == NORMAL) && !Stall_i && !Flush_i;
  assign accept      = PairReady_o && PairValidA_i;
  assign dual        = accept && PairValidB_i && !split;

  always_comb begin
    state_n = state;
    va_n    = va;
    vb_n    = vb;
    ia_n    = ia;
    ib_n    = ib;
    held_n  = held;
    if (Flush_i) begin
      state_n = NORMAL;
      va_n    = 1'b0;
      vb_n    = 1'b0;
      held_n  = NOP;
    end else if (!Stall_i) begin
      unique case (state)
        NORMAL: begin
          va_n = accept;
          vb_n = dual;
          if (accept) ia_n = InstrA_i;
          if (dual) ib_n = InstrB_i;
          if (accept && split) begin
            held_n  = InstrB_i;
            state_n = SPLIT_B;
          end
        end
        SPLIT_B: begin
          ia_n    = held;
          va_n    = 1'b1;
          vb_n    = 1'b0;
          state_n = NORMAL;
        end
        default: state_n = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= NORMAL;
      va    <= 1'b0;
      vb    <= 1'b0;
      ia    <= NOP;
      ib    <= NOP;
      held  <= NOP;
    end else begin
      state <= state_n;
      va    <= va_n;
      vb    <= vb_n;
      ia    <= ia_n;
      ib    <= ib_n;
      held  <= held_n;
    end
  end

  assign IssueValidA_o = va;
  assign IssueValidB_o = vb;
  assign IssueInstrA_o = ia;
  assign IssueInstrB_o = ib;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] dual_cnt;
  logic [31:0] split_cnt;

  // accept already excludes stall and flush, so counters hold then
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dual_cnt  <= '0;
      split_cnt <= '0;
    end else begin
      if (dual) dual_cnt <= dual_cnt + 32'd1;
      if (accept && split) split_cnt <= split_cnt + 32'd1;
    end
  end

  assign DualCount_o  = dual_cnt;
  assign SplitCount_o = split_cnt;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed and randomized checks of dual_issue_scheduler against a
// queue-based reference model of the pairing rules.
module tb_dual_issue_scheduler;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pva = 1'b0;
  logic        pvb = 1'b0;
  logic [31:0] ina = NOP;
  logic [31:0] inb = NOP;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        rdy;
  logic        iva;
  logic        ivb;
  logic [31:0] oia;
  logic [31:0] oib;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] dcnt;
  logic [31:0] scnt;
`endif

  dual_issue_scheduler #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .PairValidA_i (pva),
    .PairValidB_i (pvb),
    .InstrA_i     (ina),
    .InstrB_i     (inb),
    .Stall_i      (stall),
    .Flush_i      (flush),
    .PairReady_o  (rdy),
    .IssueValidA_o(iva),
    .IssueValidB_o(ivb),
    .IssueInstrA_o(oia),
    .IssueInstrB_o(oib)
`ifdef SCHED_PERF_CNT_EN
    ,
    .DualCount_o  (dcnt),
    .SplitCount_o (scnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_va;
  bit          m_vb;
  logic [31:0] m_ia;
  logic [31:0] m_ib;
  logic [31:0] pend[$];
  int unsigned m_dual;
  int unsigned m_split;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit wr_rd(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6f, 7'h67};
  endfunction

  function automatic bit rd_rs1(input logic [6:0] op);
    return !(op inside {7'h37, 7'h17, 7'h6f});
  endfunction

  function automatic bit rd_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic bit must_split(input logic [31:0] a,
                                    input logic [31:0] b);
    bit raw;
    bit mem;
    bit ctl;
    raw = wr_rd(a[6:0]) && a[11:7] != 0 &&
          ((rd_rs1(b[6:0]) && b[19:15] == a[11:7]) ||
           (rd_rs2(b[6:0]) && b[24:20] == a[11:7]));
    mem = (a[6:0] inside {7'h03, 7'h23}) && (b[6:0] inside {7'h03, 7'h23});
    ctl = a[6:0] inside {7'h63, 7'h6f, 7'h67};
    return raw || mem || ctl;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_va = 0; m_vb = 0; m_ia = NOP; m_ib = NOP;
      pend.delete(); m_dual = 0; m_split = 0;
    end else if (flush) begin
      m_va = 0; m_vb = 0; pend.delete();
    end else if (stall) begin
    end else if (pend.size() != 0) begin
      m_ia = pend.pop_front(); m_va = 1; m_vb = 0;
    end else if (pva) begin
      m_ia = ina; m_va = 1; m_vb = 0;
      if (pvb && must_split(ina, inb)) begin
        pend.push_back(inb); m_split++;
      end else if (pvb) begin
        m_ib = inb; m_vb = 1; m_dual++;
      end
    end else begin
      m_va = 0; m_vb = 0;
    end
  endtask

  task automatic step(input bit a_v, input bit b_v, input logic [31:0] a,
                      input logic [31:0] b, input bit st, input bit fl,
                      input bit r);
    pva = a_v; pvb = b_v; ina = a; inb = b;
    stall = st; flush = fl; rst = r;
    #1;
    if (!r) chk("ready", 32'(rdy), 32'(pend.size() == 0 && !st && !fl));
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("valid_a", 32'(iva), 32'(m_va));
    chk("valid_b", 32'(ivb), 32'(m_vb));
    if (m_va || r) chk("instr_a", oia, m_ia);
    if (m_vb || r) chk("instr_b", oib, m_ib);
`ifdef SCHED_PERF_CNT_EN
    chk("dual_cnt", dcnt, m_dual);
    chk("split_cnt", scnt, m_split);
`endif
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 8))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h6f;
      6: w[6:0] = 7'h67;
      7: w[6:0] = 7'h37;
      default: w[6:0] = 7'h17;
    endcase
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    @(negedge clk);
    step(0, 0, NOP, NOP, 0, 0, 1);
    step(0, 0, NOP, NOP, 0, 0, 1);
    chk("reset_instr_a", oia, NOP);
    // independent pair, then RAW pair split over two cycles
    step(1, 1, 32'h00100293, 32'h00200313, 0, 0, 0);
    step(1, 1, 32'h00100293, 32'h00528333, 0, 0, 0);
    step(1, 1, NOP, NOP, 0, 0, 0);
    chk("raw_second_a", oia, 32'h00528333);
    step(1, 1, 32'h00000013, 32'h00000333, 0, 0, 0);
    chk("x0_dual", 32'(ivb), 32'd1);
    step(1, 1, 32'h00012083, 32'h00412183, 0, 0, 0);
    step(0, 0, NOP, NOP, 0, 0, 0);
    step(1, 1, 32'h00208463, 32'h00200313, 0, 0, 0);
    step(0, 0, NOP, NOP, 0, 0, 0);
    // stall while holding B, then flush drops it
    step(1, 1, 32'h00100293, 32'h00528333, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, NOP, NOP, 1, 0, 0);
    chk("stall_frozen_a", oia, 32'h00100293);
    step(0, 0, NOP, NOP, 1, 1, 0);
    step(0, 0, NOP, NOP, 0, 0, 0);
    step(0, 0, NOP, NOP, 0, 0, 0);
    chk("flushed_b_gone", 32'(iva), 32'd0);
    // reset with stall while in the split state
    step(1, 1, 32'h00100293, 32'h00528333, 0, 0, 0);
    step(1, 1, NOP, NOP, 1, 0, 1);
    chk("rst_stall_nop", oia, NOP);
    step(0, 0, NOP, NOP, 0, 0, 0);
    step(1, 0, 32'h00100293, NOP, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80,
           rnd_instr(), rnd_instr(), $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Sits between the fetch stage, which delivers an instruction pair (A older, B younger), and the decode/extend stage, which has two lanes.
- Each cycle it decides whether the pair issues together or is split over two cycles.
- Splits on intra-pair RAW dependency, a memory-port conflict, or control flow in lane A.
- Outputs are registered; it holds B in a one-entry buffer while splitting.

Parameters:
DATA_WIDTH, 32, instruction width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
PairValidA_i  input  1  fetch presents valid instruction A
PairValidB_i  input  1  fetch presents valid instruction B (0 for a partial pair)
InstrA_i  input  DATA_WIDTH  older fetched instruction
InstrB_i  input  DATA_WIDTH  younger fetched instruction
Stall_i  input  1  downstream stall; hold outputs
Flush_i  input  1  redirect from execute; discard everything
PairReady_o  output  1  scheduler accepts the presented pair this cycle
IssueValidA_o  output  1  lane A output valid
IssueValidB_o  output  1  lane B output valid
IssueInstrA_o  output  DATA_WIDTH  instruction to lane A
IssueInstrB_o  output  DATA_WIDTH  instruction to lane B

Behaviour:
- Clocking: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset: state=NORMAL; both IssueValid 0; both IssueInstr 32'h0000_0013 (NOP); held buffer cleared.
- Decode rules:
  - rd written by R(0110011), I(0010011), LOAD(0000011), LUI(0110111), AUIPC(0010111), JAL(1101111), JALR(1100111).
  - rs1 read by all except LUI, AUIPC, JAL.
  - rs2 read by R, STORE(0100011), BRANCH(1100011).
  - Memory op = LOAD or STORE. Control = BRANCH, JAL, JALR.
- Split condition, with A and B both valid:
  - (A writes rd, rd!=0, and B reads rs1==rd or rs2==rd), OR
  - both memory ops, OR
  - A is control.
- States:
  - NORMAL, no split: on accept, lane A<=InstrA, lane B<=InstrB.
  - NORMAL, split: on accept, lane A<=InstrA, IssueValidB<=0; InstrB goes into the held buffer; next state SPLIT_B.
  - NORMAL, partial pair (PairValidB_i=0): issue A alone; no split state.
  - SPLIT_B: PairReady_o=0. When not stalled, lane A<=held B, IssueValidB<=0; next state NORMAL.
- PairReady_o = (state==NORMAL) && !Stall_i && !Flush_i. This is combinational.
- Accept = PairReady_o && PairValidA_i. With no accept in NORMAL and no stall, both IssueValid<=0 (bubble).
- Stall_i=1: all output and state registers hold; nothing accepted.
- Flush_i=1: has priority over Stall_i and accept. Next cycle both IssueValid=0, state=NORMAL, held buffer discarded. The pair presented that cycle is dropped.
- rst_i: same as flush, plus registers return to reset values. rst_i mid-SPLIT_B discards the held B.
- Latency: one cycle from accept to issue; split pairs take two issue cycles.
- IssueValidB_o=1 implies IssueValidA_o=1. Lane A is always the older instruction.

Optional Feature:
- Macro SCHED_PERF_CNT_EN. When defined, the block adds two outputs:
  - DualCount_o (32 bits): counts cycles with both lanes issued.
  - SplitCount_o (32 bits): counts split events.
- Both counters clear on rst_i, hold on Stall_i, and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package sched_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - NOP_INSTR = 32'h0000_0013;
  - typedef enum logic {NORMAL, SPLIT_B} sched_state_t.
- One natural sub-module: pair_hazard_check (combinational). Inputs are InstrA, InstrB and ValidB; output is split_o. It is instantiated once and unit-testable standalone.

Test Plan:
- Independent pair: A=0x00100293 (addi x5,x0,1), B=0x00200313 (addi x6,x0,2) -> next cycle IssueValidA/B=1/1 with those instructions; PairReady stays 1.
- RAW pair: A=0x00100293, B=0x00528333 (add x6,x5,x5) -> cycle1: lane A=0x00100293, IssueValidB=0; cycle2: lane A=0x00528333; PairReady_o=0 during SPLIT_B.
- x0 destination: A=0x00000013, B=0x00000333 (add x6,x0,x0) -> dual issue, no split.
- Memory conflict: A=0x00012083 (lw x1,0(x2)), B=0x00412183 (lw x3,4(x2)) -> split, two issue cycles. Branch in A: A=0x00208463 (beq x1,x2,8), B=0x00200313 -> split.
- Stall and flush in SPLIT_B:
  - Stall_i high for 3 cycles -> outputs frozen.
  - Then Flush_i -> both valid 0, state NORMAL, held B never issued.
  - rst_i asserted together with Stall_i -> NOP outputs, valids 0.
